mw_controller: RTL and testbench
================================

// Module: mw_controller
// PURPOSE
//  Microwave sequencing FSM that drives the countdown timer (number/loadn/clearn/enable).
//  Takes keypad digits, start, stop and the door switch; loads digits into the timer, gates
//  countdown ticks, drives the magnetron and signals end of cook. Sits between the top-level
//  user inputs and the timer instance.
// PARAMETERS
//  TICK_DIV     default 10  clocks per countdown tick; timer_enable pulses once per TICK_DIV in COOK
//  BEEP_CYCLES  default 20  clocks that done_beep stays high in DONE
//  MAX_DIGITS   default 3   max digits accepted per entry (mins, sec_tens, sec_ones)
// PORTS
//  clock         in   1  single clock; all state updates on rising edge
//  clear         in   1  synchronous reset, active-high
//  key_valid     in   1  one-cycle strobe: key_value holds a keypad digit
//  key_value     in   4  BCD digit 0..9
//  start         in   1  start button level; rising edge acts
//  stop          in   1  stop/cancel button level; rising edge acts
//  door_closed   in   1  1 = door closed
//  timer_zero    in   1  timer reports 0:00
//  timer_number  out  4  digit presented to timer
//  timer_loadn   out  1  active-low one-cycle load strobe to timer
//  timer_clearn  out  1  active-low one-cycle clear to timer
//  timer_enable  out  1  one-cycle countdown tick to timer
//  mag_on        out  1  magnetron drive
//  done_beep     out  1  end-of-cook indicator
//  state_o       out  3  current FSM state (debug)
// BEHAVIOUR
//  All outputs registered. While clear=1: state IDLE, digit count 0, tick counter 0,
//   timer_clearn=0, timer_loadn=1, timer_enable=0, timer_number=0, mag_on=0, done_beep=0.
//   First cycle after clear drops: timer_clearn=1. Clear mid-cook aborts immediately.
//  start/stop edge-detected (registered previous value); same-cycle start and stop edges: stop wins.
//  States: IDLE=0, ENTRY=1, COOK=2, PAUSE=3, DONE=4, QLOAD=5 (QLOAD only with macro).
//  IDLE : key_valid with key_value<=9 -> ENTRY, digit count=1. start edge ignored (no time set).
//  ENTRY: each valid digit (<=9, count<MAX_DIGITS) -> next cycle timer_number=key_value,
//    timer_loadn=0 for exactly one cycle, count+1. key_value>9 or count==MAX_DIGITS: ignored.
//    start edge & door_closed & !timer_zero -> COOK, tick counter cleared.
//    start edge with door open: ignored. stop edge -> timer_clearn=0 one cycle, count=0, IDLE.
//  COOK : mag_on=1; tick counter counts 0..TICK_DIV-1, timer_enable=1 for the one cycle when it
//    wraps to 0. timer_zero=1 -> DONE next edge, mag_on and timer_enable 0 same edge.
//    door_closed=0 or stop edge -> PAUSE next edge (mag_on=0, tick counter held, not cleared).
//    Keys ignored.
//  PAUSE: mag_on=0, no ticks. start edge & door_closed -> COOK, tick counter resumes.
//    stop edge -> clear timer (timer_clearn=0 one cycle), count=0, IDLE.
//  DONE : done_beep=1 for BEEP_CYCLES clocks then IDLE; stop edge or door opening ends it early
//    (-> IDLE next edge). Count reset to 0 on entry.
//  Latency: key strobe at edge N -> loadn low during cycle N+1; start edge -> mag_on at N+1.
// CONFIGURATION
//  `define MW_QUICK_START_EN: start edge in IDLE with door_closed -> QLOAD: loads digit 3 then
//    digit 0 (two loadn pulses, one idle cycle between), then COOK (30 s quick start).
//    stop during QLOAD -> clear, IDLE.
//  Without macro: QLOAD absent; start in IDLE ignored.
// STRUCTURE
//  mw_defs.vh (shared include): state encodings, DIGIT_W=4, QUICK_START digits 3,0.
//  Sub-module mw_tick_gen: prescaler with run/hold/clear inputs, tick output; width
//   $clog2(TICK_DIV). Remainder of FSM in mw_controller.
// TESTING
//  clear 2 cycles -> all outputs at reset values, timer_clearn=0 during, state_o=0.
//  keys 2,1,9 -> three loadn pulses with timer_number 2,1,9; 4th key 5 -> no pulse.
//  start with door_closed=0 after entry -> stays ENTRY; door_closed=1 + start -> mag_on next
//   cycle, timer_enable every 10 clocks.
//  door opens mid-COOK -> mag_on=0, no ticks; close + start -> ticks resume at held phase.
//  timer_zero=1 in COOK -> DONE, done_beep 20 cycles, then IDLE; start+stop same cycle in
//   PAUSE -> timer_clearn pulse, IDLE.
//  MW_QUICK_START_EN: start in IDLE -> loadn pulses with numbers 3 then 0, then COOK; without
//   macro -> no response.

Source files
------------

// File: rtl/mw_controller_pkg.sv
// Shared types and constants for the microwave sequencing controller.
// Build option: MW_QUICK_START_EN enables the one-button 30 s quick start (QLOAD state).
package mw_controller_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] MAX_KEY        = 4'd9;
  localparam logic [DIGIT_W-1:0] QUICK_DIGIT_HI = 4'd3;
  localparam logic [DIGIT_W-1:0] QUICK_DIGIT_LO = 4'd0;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StEntry = 3'd1,
    StCook  = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4,
    StQload = 3'd5
  } mw_state_e;

  function automatic logic key_ok(input logic valid, input logic [DIGIT_W-1:0] digit);
    return valid && (digit <= MAX_KEY);
  endfunction

endpackage

// File: rtl/mw_controller_if.sv
// User-input and timer-side signal bundle for mw_controller.
// master: the side driving keypad/buttons/door/timer_zero; slave: the controller.
interface mw_controller_if;
  import mw_controller_pkg::*;

  logic               key_valid;
  logic [DIGIT_W-1:0] key_value;
  logic               start;
  logic               stop;
  logic               door_closed;
  logic               timer_zero;
  logic [DIGIT_W-1:0] timer_number;
  logic               timer_loadn;
  logic               timer_clearn;
  logic               timer_enable;
  logic               mag_on;
  logic               done_beep;
  logic [2:0]         state_o;

  modport master (
    output key_valid, key_value, start, stop, door_closed, timer_zero,
    input  timer_number, timer_loadn, timer_clearn, timer_enable, mag_on, done_beep, state_o
  );

  modport slave (
    input  key_valid, key_value, start, stop, door_closed, timer_zero,
    output timer_number, timer_loadn, timer_clearn, timer_enable, mag_on, done_beep, state_o
  );

endinterface

// File: rtl/mw_tick_gen.sv
// Countdown prescaler: counts 0..TICK_DIV-1 while running, flags the wrap back to 0.
// Hold freezes the phase so a paused cook resumes where it stopped.
module mw_tick_gen #(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic i_clock,
  input  logic i_clear,
  input  logic i_run,
  input  logic i_hold,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CntW-1:0] r_cnt;
  logic            w_last;
  logic            w_adv;

  assign w_last = (r_cnt == CntW'(TICK_DIV - 1));
  assign w_adv  = i_run && !i_hold && !i_clr;
  assign o_tick = w_adv && w_last;

  always_ff @(posedge i_clock) begin
    if (i_clear || i_clr) begin
      r_cnt <= '0;
    end else if (w_adv) begin
      r_cnt <= w_last ? '0 : r_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/mw_controller.sv
// Microwave sequencing FSM driving the countdown timer, magnetron and end-of-cook beep.
// Build option: MW_QUICK_START_EN adds quick start (start in IDLE loads 3:0 and cooks).
module mw_controller
  import mw_controller_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 10,
  parameter int unsigned BEEP_CYCLES = 20,
  parameter int unsigned MAX_DIGITS  = 3
) (
  input  logic     i_clock,
  input  logic     i_clear,
  mw_controller_if.slave io_bus
);

  localparam int unsigned CountW = $clog2(MAX_DIGITS + 1);
  localparam int unsigned BeepW  = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;

  mw_state_e          r_state, w_state_d;
  logic [CountW-1:0]  r_count, w_count_d;
  logic [BeepW-1:0]   r_beep, w_beep_d;
  logic               r_start_q, r_stop_q;
  logic [DIGIT_W-1:0] r_number, w_number_d;
  logic               r_loadn, w_loadn_d;
  logic               r_clearn, w_clearn_d;
  logic               r_enable;
  logic               r_mag_on;
  logic               r_done_beep;
`ifdef MW_QUICK_START_EN
  logic [1:0]         r_qstep, w_qstep_d;
`endif

  logic w_key_ok;
  logic w_stop_edge;
  logic w_start_go;
  logic w_tick_run;
  logic w_tick_clr;
  logic w_tick;

  assign w_key_ok    = key_ok(io_bus.key_valid, io_bus.key_value);
  assign w_stop_edge = io_bus.stop && !r_stop_q;
  // Simultaneous start and stop edges resolve to stop.
  assign w_start_go  = io_bus.start && !r_start_q && !w_stop_edge;

  // Prescaler advances only on cycles that begin and end in COOK.
  assign w_tick_run = (r_state == StCook) && (w_state_d == StCook);

  mw_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .i_clock (i_clock),
    .i_clear (i_clear),
    .i_run   (w_tick_run),
    .i_hold  (!w_tick_run),
    .i_clr   (w_tick_clr),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_state_d  = r_state;
    w_count_d  = r_count;
    w_beep_d   = r_beep;
    w_number_d = r_number;
    w_loadn_d  = 1'b1;
    w_clearn_d = 1'b1;
    w_tick_clr = 1'b0;
`ifdef MW_QUICK_START_EN
    w_qstep_d  = r_qstep;
`endif
    case (r_state)
      StIdle: begin
        if (w_key_ok) begin
          w_number_d = io_bus.key_value;
          w_loadn_d  = 1'b0;
          w_count_d  = CountW'(1);
          w_state_d  = StEntry;
`ifdef MW_QUICK_START_EN
        end else if (w_start_go && io_bus.door_closed) begin
          w_number_d = QUICK_DIGIT_HI;
          w_loadn_d  = 1'b0;
          w_qstep_d  = 2'd0;
          w_state_d  = StQload;
`endif
        end
      end
      StEntry: begin
        if (w_stop_edge) begin
          w_clearn_d = 1'b0;
          w_count_d  = '0;
          w_state_d  = StIdle;
        end else if (w_start_go && io_bus.door_closed && !io_bus.timer_zero) begin
          w_tick_clr = 1'b1;
          w_state_d  = StCook;
        end else if (w_key_ok && (r_count < CountW'(MAX_DIGITS))) begin
          w_number_d = io_bus.key_value;
          w_loadn_d  = 1'b0;
          w_count_d  = r_count + CountW'(1);
        end
      end
      StCook: begin
        if (io_bus.timer_zero) begin
          w_beep_d  = '0;
          w_count_d = '0;
          w_state_d = StDone;
        end else if (!io_bus.door_closed || w_stop_edge) begin
          w_state_d = StPause;
        end
      end
      StPause: begin
        if (w_stop_edge) begin
          w_clearn_d = 1'b0;
          w_count_d  = '0;
          w_state_d  = StIdle;
        end else if (w_start_go && io_bus.door_closed) begin
          w_state_d = StCook;
        end
      end
      StDone: begin
        if (w_stop_edge || !io_bus.door_closed) begin
          w_state_d = StIdle;
        end else if (r_beep == BeepW'(BEEP_CYCLES - 1)) begin
          w_state_d = StIdle;
        end else begin
          w_beep_d = r_beep + BeepW'(1);
        end
      end
`ifdef MW_QUICK_START_EN
      StQload: begin
        if (w_stop_edge) begin
          w_clearn_d = 1'b0;
          w_count_d  = '0;
          w_state_d  = StIdle;
        end else begin
          // Step 0 = first load done, step 1 = gap cycle, step 2 = second load done.
          case (r_qstep)
            2'd0: w_qstep_d = 2'd1;
            2'd1: begin
              w_number_d = QUICK_DIGIT_LO;
              w_loadn_d  = 1'b0;
              w_qstep_d  = 2'd2;
            end
            default: begin
              w_tick_clr = 1'b1;
              w_state_d  = StCook;
            end
          endcase
        end
      end
`endif
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_state     <= StIdle;
      r_count     <= '0;
      r_beep      <= '0;
      r_start_q   <= 1'b0;
      r_stop_q    <= 1'b0;
      r_number    <= '0;
      r_loadn     <= 1'b1;
      r_clearn    <= 1'b0;
      r_enable    <= 1'b0;
      r_mag_on    <= 1'b0;
      r_done_beep <= 1'b0;
`ifdef MW_QUICK_START_EN
      r_qstep     <= 2'd0;
`endif
    end else begin
      r_state     <= w_state_d;
      r_count     <= w_count_d;
      r_beep      <= w_beep_d;
      r_start_q   <= io_bus.start;
      r_stop_q    <= io_bus.stop;
      r_number    <= w_number_d;
      r_loadn     <= w_loadn_d;
      r_clearn    <= w_clearn_d;
      r_enable    <= w_tick;
      r_mag_on    <= (w_state_d == StCook);
      r_done_beep <= (w_state_d == StDone);
`ifdef MW_QUICK_START_EN
      r_qstep     <= w_qstep_d;
`endif
    end
  end

  assign io_bus.timer_number = r_number;
  assign io_bus.timer_loadn  = r_loadn;
  assign io_bus.timer_clearn = r_clearn;
  assign io_bus.timer_enable = r_enable;
  assign io_bus.mag_on       = r_mag_on;
  assign io_bus.done_beep    = r_done_beep;
  assign io_bus.state_o      = r_state;

endmodule

// File: tb/tb_mw_controller.sv
// Scoreboard bench for mw_controller: directed scenarios, then a randomized run,
// each cycle checked against a behavioural model of the sequencing rules.
module tb_mw_controller;

  localparam int unsigned TickDiv    = 10;
  localparam int unsigned BeepCycles = 20;
  localparam int unsigned MaxDigits  = 3;
`ifdef MW_QUICK_START_EN
  localparam bit Quick = 1'b1;
`else
  localparam bit Quick = 1'b0;
`endif

  // Spec state codes
  localparam int SIdle = 0, SEntry = 1, SCook = 2, SPause = 3, SDone = 4, SQload = 5;

  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  mw_controller_if bus ();

  mw_controller #(
    .TICK_DIV    (TickDiv),
    .BEEP_CYCLES (BeepCycles),
    .MAX_DIGITS  (MaxDigits)
  ) dut (
    .i_clock (clock),
    .i_clear (clear),
    .io_bus  (bus)
  );

  typedef struct {
    int         cyc;
    logic [2:0] state;
    logic [3:0] number;
    logic       loadn;
    logic       clearn;
    logic       enable;
    logic       mag;
    logic       beep;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Stimulus levels for the current cycle
  logic       m_clear, m_kv, m_start, m_stop, m_door, m_zero;
  logic [3:0] m_kval;

  // Behavioural model: mode, digits entered, cook phase, beep time, quick-load step
  int   md_state, md_count, md_phase, md_beep, md_q;
  logic md_ps, md_pp;
  logic [3:0] md_number;

  task automatic model_step(output exp_t e);
    logic se, pe, kok;
    e.loadn  = 1'b1;
    e.clearn = 1'b1;
    e.enable = 1'b0;
    if (m_clear) begin
      md_state = SIdle; md_count = 0; md_phase = 0; md_beep = 0; md_q = 0;
      md_ps = 1'b0; md_pp = 1'b0; md_number = 4'd0;
      e.clearn = 1'b0;
    end else begin
      pe  = m_stop && !md_pp;
      se  = m_start && !md_ps && !pe;
      kok = m_kv && (m_kval <= 4'd9);
      case (md_state)
        SIdle: begin
          if (kok) begin
            md_number = m_kval; e.loadn = 1'b0; md_count = 1; md_state = SEntry;
          end else if (Quick && se && m_door) begin
            md_number = 4'd3; e.loadn = 1'b0; md_q = 0; md_state = SQload;
          end
        end
        SEntry: begin
          if (pe) begin
            e.clearn = 1'b0; md_count = 0; md_state = SIdle;
          end else if (se && m_door && !m_zero) begin
            md_phase = 0; md_state = SCook;
          end else if (kok && md_count < MaxDigits) begin
            md_number = m_kval; e.loadn = 1'b0; md_count++;
          end
        end
        SCook: begin
          if (m_zero) begin
            md_beep = 0; md_count = 0; md_state = SDone;
          end else if (!m_door || pe) begin
            md_state = SPause;
          end else begin
            md_phase = (md_phase + 1) % TickDiv;
            if (md_phase == 0) e.enable = 1'b1;
          end
        end
        SPause: begin
          if (pe) begin
            e.clearn = 1'b0; md_count = 0; md_state = SIdle;
          end else if (se && m_door) begin
            md_state = SCook;
          end
        end
        SDone: begin
          if (pe || !m_door) md_state = SIdle;
          else begin
            md_beep++;
            if (md_beep == BeepCycles) md_state = SIdle;
          end
        end
        SQload: begin
          if (pe) begin
            e.clearn = 1'b0; md_count = 0; md_state = SIdle;
          end else begin
            md_q++;
            if (md_q == 2) begin md_number = 4'd0; e.loadn = 1'b0; end
            if (md_q == 3) begin md_phase = 0; md_state = SCook; end
          end
        end
        default: md_state = SIdle;
      endcase
      md_ps = m_start;
      md_pp = m_stop;
    end
    e.state  = 3'(md_state);
    e.number = md_number;
    e.mag    = (md_state == SCook);
    e.beep   = (md_state == SDone);
    e.cyc    = cyc + 1;
  endtask

  // Apply this cycle's stimulus, predict the post-edge outputs, advance one clock
  task automatic cycle();
    exp_t e;
    clear            = m_clear;
    bus.key_valid    = m_kv;
    bus.key_value    = m_kval;
    bus.start        = m_start;
    bus.stop         = m_stop;
    bus.door_closed  = m_door;
    bus.timer_zero   = m_zero;
    model_step(e);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic key(input logic [3:0] v);
    m_kv = 1'b1; m_kval = v; cycle();
    m_kv = 1'b0; cycle();
  endtask

  task automatic press_start();
    m_start = 1'b1; cycle();
    m_start = 1'b0; cycle();
  endtask

  task automatic press_stop();
    m_stop = 1'b1; cycle();
    m_stop = 1'b0; cycle();
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL scoreboard_stale cycle=%0d expected_at=%0d", cyc, e.cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.state_o !== e.state || bus.timer_loadn !== e.loadn ||
          bus.timer_clearn !== e.clearn || bus.timer_enable !== e.enable ||
          bus.mag_on !== e.mag || bus.done_beep !== e.beep ||
          (e.loadn == 1'b0 && bus.timer_number !== e.number)) begin
        errors++;
        $display("FAIL outputs cycle=%0d got st=%0d ld=%b num=%0d clr=%b en=%b mag=%b beep=%b exp st=%0d ld=%b num=%0d clr=%b en=%b mag=%b beep=%b",
                 cyc, bus.state_o, bus.timer_loadn, bus.timer_number, bus.timer_clearn,
                 bus.timer_enable, bus.mag_on, bus.done_beep, e.state, e.loadn, e.number,
                 e.clearn, e.enable, e.mag, e.beep);
      end
    end
  end

  initial begin
    m_clear = 1'b1; m_kv = 1'b0; m_kval = 4'd0; m_start = 1'b0; m_stop = 1'b0;
    m_door = 1'b0; m_zero = 1'b0;
    clear = 1'b1;
    bus.key_valid = 1'b0; bus.key_value = 4'd0; bus.start = 1'b0; bus.stop = 1'b0;
    bus.door_closed = 1'b0; bus.timer_zero = 1'b0;
    @(posedge clock);
    #1;

    // Reset held two cycles
    idle(2);
    m_clear = 1'b0;
    idle(2);

    // Entry 2,1,(bad 12),9 then a rejected 4th digit
    key(4'd2); key(4'd1); key(4'd12); key(4'd9); key(4'd5);

    // Start with door open is ignored, then close and cook
    press_start();
    m_door = 1'b1; idle(2);
    press_start();
    idle(TickDiv * 3 + $urandom_range(7));

    // Door opens mid-cook, then close and resume
    m_door = 1'b0; idle(5 + $urandom_range(4));
    m_door = 1'b1; idle(2);
    press_start();
    idle(TickDiv + 5);

    // Timer reaches zero: beep then back to idle
    m_zero = 1'b1; cycle();
    m_zero = 1'b0; idle(BeepCycles + 4);

    // Pause via stop, then simultaneous start and stop
    key(4'($urandom_range(9)));
    press_start();
    idle(6);
    press_stop();
    idle(2);
    m_start = 1'b1; m_stop = 1'b1; cycle();
    m_start = 1'b0; m_stop = 1'b0; idle(3);

    // Start in IDLE: quick start when enabled, otherwise no response
    press_start();
    idle(TickDiv * 2 + 3);
    press_stop();
    idle(2);
    press_stop();
    idle(3);

    // DONE ended early by door opening
    key(4'($urandom_range(9)));
    press_start();
    idle(3);
    m_zero = 1'b1; cycle();
    m_zero = 1'b0; idle(5);
    m_door = 1'b0; idle(3);
    m_door = 1'b1; idle(2);

    // Randomized run
    for (int i = 0; i < 4000; i++) begin
      m_clear = ($urandom_range(999) < 3);
      m_kv    = ($urandom_range(99) < 20);
      m_kval  = 4'($urandom_range(15));
      if ($urandom_range(99) < 8) m_start = ~m_start;
      m_stop  = ($urandom_range(99) < 3);
      if ($urandom_range(99) < 3) m_door = ~m_door;
      m_zero  = ($urandom_range(99) < 2);
      cycle();
    end

    m_clear = 1'b0; m_kv = 1'b0; m_start = 1'b0; m_stop = 1'b0; m_zero = 1'b0;
    idle(2);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
